// File: rtl/spi_master_ctrl.sv
// SPI master command controller: serialises a 10-bit {cmd, data} frame on MOSI, optionally reads a byte back on MISO.
// Latency: 13 cycles accept-to-ready for writes, 21+RD_LATENCY for reads; all outputs registered.
// Backpressure: cmd_ready only in IDLE; cmd_valid is ignored while busy. Optional macro SPI_MASTER_RDADDR_CHECK_EN rejects reads before an address write.
module spi_master_ctrl #(
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       rd_err
);

  typedef enum logic [2:0] {
    IDLE, SELECT, SHIFT_OUT, TURNAROUND, SHIFT_IN, DESELECT
  } state_t;

  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam logic [3:0] TA_LAST     = 4'(RD_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [9:0] tx, tx_nxt;
  logic [1:0] cmd_q, cmd_q_nxt;
  logic [7:0] rx, rx_nxt;
  logic [7:0] rd_data_nxt;
  logic       rd_valid_nxt;
  logic       ss_n_nxt;
  logic       mosi_nxt;
  logic       ready_nxt;
`ifdef SPI_MASTER_RDADDR_CHECK_EN
  logic       addr_set, addr_set_nxt;
  logic       rd_err_nxt;
`endif

  // Next-state and next-output logic; every output register is loaded from
  // the value its state will have next cycle, so outputs line up with state.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 4'd1;
    tx_nxt       = tx;
    cmd_q_nxt    = cmd_q;
    rx_nxt       = rx;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = 1'b0;
`ifdef SPI_MASTER_RDADDR_CHECK_EN
    addr_set_nxt = addr_set;
    rd_err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (cmd_valid) begin
          tx_nxt    = {cmd, (cmd == CMD_RD_DATA) ? 8'h00 : cmd_data};
          cmd_q_nxt = cmd;
          state_nxt = SELECT;
`ifdef SPI_MASTER_RDADDR_CHECK_EN
          // A data read with no address programmed is consumed and flagged, no bus activity.
          if (cmd == CMD_RD_DATA && !addr_set) begin
            state_nxt  = IDLE;
            rd_err_nxt = 1'b1;
          end
`endif
        end
      end
      SELECT: begin
        state_nxt = SHIFT_OUT;
        cnt_nxt   = 4'd0;
      end
      SHIFT_OUT: begin
        tx_nxt = {tx[8:0], 1'b0};
        if (cnt == 4'd9) begin
          state_nxt = (cmd_q == CMD_RD_DATA) ? TURNAROUND : DESELECT;
          cnt_nxt   = 4'd0;
        end
      end
      TURNAROUND: begin
        if (cnt == TA_LAST) begin
          state_nxt = SHIFT_IN;
          cnt_nxt   = 4'd0;
        end
      end
      SHIFT_IN: begin
        rx_nxt = {rx[6:0], MISO};
        if (cnt == 4'd7) begin
          state_nxt    = DESELECT;
          cnt_nxt      = 4'd0;
          rd_data_nxt  = {rx[6:0], MISO};
          rd_valid_nxt = 1'b1;
        end
      end
      DESELECT: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
`ifdef SPI_MASTER_RDADDR_CHECK_EN
        if (cmd_q == CMD_RD_ADDR) addr_set_nxt = 1'b1;
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
    ss_n_nxt  = (state_nxt == IDLE) || (state_nxt == DESELECT);
    // The MSB of the shift register is the bit on the wire during SHIFT_OUT.
    mosi_nxt  = (state_nxt == SHIFT_OUT) ? tx_nxt[9] : 1'b0;
    ready_nxt = (state_nxt == IDLE);
  end

  // State, datapath and registered outputs; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      tx        <= 10'd0;
      cmd_q     <= 2'b00;
      rx        <= 8'h00;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tx        <= tx_nxt;
      cmd_q     <= cmd_q_nxt;
      rx        <= rx_nxt;
      SS_n      <= ss_n_nxt;
      MOSI      <= mosi_nxt;
      rd_data   <= rd_data_nxt;
      rd_valid  <= rd_valid_nxt;
      cmd_ready <= ready_nxt;
      busy      <= !ready_nxt;
    end
  end

`ifdef SPI_MASTER_RDADDR_CHECK_EN
  // Address-programmed flag and read-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_set <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      addr_set <= addr_set_nxt;
      rd_err   <= rd_err_nxt;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
- REQ-001 SHALL have parameter RD_LATENCY, default 2: idle cycles between the last MOSI bit and the first MISO sample, legal range 1..15.
- REQ-002 SHALL have port clk, input, 1: system clock; all SPI signalling is synchronous to clk, so no separate SCLK.
- REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-004 SHALL have port cmd_valid, input, 1: command request.
- REQ-005 SHALL have port cmd_ready, output, 1: high only in IDLE; a command is accepted on a clk edge where cmd_valid and cmd_ready are both high.
- REQ-006 SHALL have port cmd, input, 2: 00 write address, 01 write data, 10 read address, 11 read data.
- REQ-007 SHALL have port cmd_data, input, 8: payload; ignored (sent as 0x00) for cmd 11.
- REQ-008 SHALL have port SS_n, output, 1: slave select, active-low.
- REQ-009 SHALL have port MOSI, output, 1: serial data to the slave.
- REQ-010 SHALL have port MISO, input, 1: serial data from the slave.
- REQ-011 SHALL have port rd_data, output, 8: last byte read back.
- REQ-012 SHALL have port rd_valid, output, 1: one-cycle pulse, rd_data is new.
- REQ-013 SHALL have port busy, output, 1: the inverse of cmd_ready.

Function
- REQ-014 SHALL implement the FSM states IDLE, SELECT, SHIFT_OUT, TURNAROUND, SHIFT_IN and DESELECT, with all outputs registered.
- REQ-015 SHALL, on acceptance in IDLE, latch the frame {cmd, cmd_data} (10 bits) and go to SELECT.
- REQ-016 SHALL, in SELECT (1 cycle), drive SS_n=0 and MOSI=0, then go to SHIFT_OUT.
- REQ-017 SHALL, in SHIFT_OUT (10 cycles), drive frame bits 9 down to 0 on MOSI, MSB first, one bit per cycle, with SS_n held at 0.
- REQ-018 SHALL, after SHIFT_OUT, go to TURNAROUND for cmd 11 and to DESELECT otherwise.
- REQ-019 SHALL, in TURNAROUND (RD_LATENCY cycles), hold SS_n=0 and MOSI=0.
- REQ-020 SHALL, in SHIFT_IN (8 cycles), sample MISO on each clk edge, MSB first, into a shift register, with SS_n held at 0.
- REQ-021 SHALL, on the cycle after the 8th sample, load rd_data and pulse rd_valid high for exactly 1 cycle.
- REQ-022 SHALL, in DESELECT (1 cycle), drive SS_n=1, then return to IDLE, with cmd_ready rising on the following cycle.
- REQ-023 SHALL hold SS_n low for exactly 11 cycles for cmd 00/01/10, and for 19+RD_LATENCY cycles for cmd 11.
- REQ-024 SHALL keep SS_n high for at least 1 cycle between consecutive frames (the DESELECT cycle).
- REQ-025 SHALL ignore cmd_valid while busy; the command inputs SHALL NOT be sampled mid-frame.
- REQ-026 SHALL keep the bit counter 4 bits wide; it resets to 0 on every state change and never wraps within a state.
- REQ-027 SHALL hold rd_data until the next completed read.

Reset
- REQ-028 SHALL, on rst_n low (asynchronous, any state, including mid-frame), force: state IDLE, SS_n=1, MOSI=0, rd_data=0x00, rd_valid=0, cmd_ready=1 after deassertion, busy=0, counters 0.
- REQ-029 SHALL NOT emit a partial rd_valid when reset interrupts a frame; the aborted frame is discarded.

Configuration
- REQ-030 SHALL, when macro SPI_MASTER_RDADDR_CHECK_EN is defined, track an internal flag addr_set, cleared by reset and set when a cmd 10 frame completes.
- REQ-031 SHALL, with that macro defined, accept a cmd 11 issued while addr_set=0 for one cycle, generate no SS_n activity, drive rd_valid=0, and pulse output rd_err for 1 cycle.
- REQ-032 SHALL, when the macro is undefined, omit addr_set, send every cmd 11 frame, and tie rd_err to 0.

Verification
- REQ-033 SHALL cover a write address: cmd=00, cmd_data=0xA5 -> SS_n low 11 cycles, MOSI = 0, then 00_1010_0101, then SS_n=1 for 1 cycle, cmd_ready high again 13 cycles after acceptance.
- REQ-034 SHALL cover a read sequence: cmd=10 with 0x3C, then cmd=11; slave model drives 0x96 on MISO starting RD_LATENCY=2 cycles after the last MOSI bit -> rd_data=0x96, a single rd_valid pulse, SS_n low 21 cycles.
- REQ-035 SHALL cover back-to-back requests: cmd_valid held high with 4 queued commands -> exactly 1 SS_n-high cycle between frames, no command lost or duplicated.
- REQ-036 SHALL cover reset mid-frame: rst_n low at SHIFT_IN bit 4 of a read -> SS_n=1 immediately, rd_valid never pulses, rd_data=0x00, next write frame correct.
- REQ-037 SHALL cover reads with the macro defined: cmd=11 after reset with no prior cmd 10 -> rd_err pulse, SS_n stays 1; after cmd 10, cmd 11 -> normal read, rd_err=0.
- REQ-038 SHALL cover the RD_LATENCY sweep: RD_LATENCY=1 and 15 with MISO pattern 0x01 -> rd_data=0x01 in both builds.
